enc_code_checker: RTL
=====================

# enc_code_checker

Downstream companion of the 32-bit code encoder. Consumes the registered encoded word, maps each legal codeword back to its source symbol, and classifies everything else as a miss or an error. Results are buffered in a small first-word-fall-through FIFO behind a valid/ready handshake, and the block keeps saturating hit and error statistics. It sits between the encoder output register and the downstream consumer/scoreboard.

## Interface
- WIDTH, 32, data width; codeword constants are defined for 32 only.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  data_in carries a word this cycle.
- data_in  in  WIDTH  encoded word from the encoder.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer accepts the head this cycle.
- data_out  out  WIDTH  decoded symbol or raw word (see kind).
- out_kind  out  2  0 = hit, 1 = miss, 2 = error; 3 is never produced.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.
- hit_cnt  out  CNT_W  accepted hits, saturating.
- err_cnt  out  CNT_W  accepted errors, saturating.

## Operation
Classification is combinational on data_in:
- 0x0000058F -> hit, symbol 0.
- 0xFFFFFA70 -> hit, symbol 123.
- 0xFF807017 -> hit, symbol 1023.
- 0x007B8FF7 -> hit, symbol 10023.
- 0xFFFFF05F -> hit, symbol 7000.
- 0x00000000 -> miss (the encoder's default output); data_out = 0.
- Any other value -> error; data_out = data_in unchanged.

Push and pop:
- Push when in_valid and (not full, or a pop occurs in the same cycle). Each FIFO entry stores {kind, data}.
- Pop when out_valid and out_ready.
- Full with in_valid and no pop: the word is dropped, overflow is set, and the counters do not change.

Flags and counters:
- overflow clears only on reset.
- hit_cnt and err_cnt increment on accepted pushes of the matching kind. They hold at 2^CNT_W-1 and never wrap.
- Misses are not counted.

FIFO structure:
- Read and write pointers are log2(DEPTH)+1 bits; they wrap modulo 2*DEPTH.
- full: pointers differ only in the MSB.
- empty: pointers are equal.

## Timing
- Reset (rst low, any time, asynchronous) does all of the following. Everything returns to normal operation on the first edge after rst goes high.
  - FIFO empties.
  - out_valid = 0, data_out = 0, out_kind = 0.
  - overflow = 0, hit_cnt = 0, err_cnt = 0.
  - A word presented during reset is discarded.
- Latency:
  - A word accepted at edge N is visible at the head with out_valid = 1 after edge N, provided the FIFO was empty.
  - Otherwise it appears after all older entries have popped.
- data_out and out_kind are stable while out_valid = 1 and out_ready = 0.
- When empty, data_out and out_kind hold their last value and out_valid = 0.
- Simultaneous push and pop:
  - When full: both happen, occupancy unchanged, no overflow.
  - When empty: the push happens, but there is nothing to pop, so the new word becomes the head.
- Counters and overflow update on the same edge as the accepting or dropping push. They are registered outputs.
- Throughput is one word per cycle sustained when out_ready is held high.

## Test plan
- Reset, then present the five legal codewords back-to-back with out_ready = 1:
  - data_out sequence 0, 123, 1023, 10023, 7000; all kinds 0.
  - hit_cnt = 5; each result appears one cycle after its input.
- Present 0x00000000, then 0x12345678:
  - Results: kind 1 with data 0, then kind 2 with data 0x12345678.
  - hit_cnt unchanged, err_cnt = 1.
- Hold out_ready = 0 and push 6 words 0x0000058F with DEPTH = 4:
  - 4 entries accepted; overflow rises on the 5th push; hit_cnt = 4.
  - Then raise out_ready: exactly 4 results drain, then out_valid = 0.
- With the FIFO full, assert in_valid and out_ready in the same cycle:
  - Occupancy stays 4, overflow stays 0, the new word lands at the tail.
- With CNT_W forced to 2, push 5 errors (0xDEADBEEF):
  - err_cnt saturates at 3.
- Assert rst low mid-burst, between clock edges:
  - out_valid, overflow and both counters go to 0 immediately.
  - After release, the first pushed word emerges correctly.

Source files
------------

// File: rtl/enc_code_checker.sv
// Decodes encoder codewords into hit/miss/error results, buffers them in a
// first-word-fall-through FIFO and keeps saturating hit/error statistics.
module enc_code_checker #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       out_kind,
    output logic             overflow,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = WIDTH + 2;

    localparam logic [1:0] KIND_HIT  = 2'd0;
    localparam logic [1:0] KIND_MISS = 2'd1;
    localparam logic [1:0] KIND_ERR  = 2'd2;

    localparam logic [WIDTH-1:0] CW_0     = WIDTH'(32'h0000058F);
    localparam logic [WIDTH-1:0] CW_123   = WIDTH'(32'hFFFFFA70);
    localparam logic [WIDTH-1:0] CW_1023  = WIDTH'(32'hFF807017);
    localparam logic [WIDTH-1:0] CW_10023 = WIDTH'(32'h007B8FF7);
    localparam logic [WIDTH-1:0] CW_7000  = WIDTH'(32'hFFFFF05F);
    localparam logic [WIDTH-1:0] CW_NONE  = '0;

    logic [1:0]       cls_kind;
    logic [WIDTH-1:0] cls_data;

    always_comb begin
        cls_kind = KIND_ERR;
        cls_data = data_in;
        case (data_in)
            CW_0:     begin cls_kind = KIND_HIT;  cls_data = WIDTH'(0);     end
            CW_123:   begin cls_kind = KIND_HIT;  cls_data = WIDTH'(123);   end
            CW_1023:  begin cls_kind = KIND_HIT;  cls_data = WIDTH'(1023);  end
            CW_10023: begin cls_kind = KIND_HIT;  cls_data = WIDTH'(10023); end
            CW_7000:  begin cls_kind = KIND_HIT;  cls_data = WIDTH'(7000);  end
            CW_NONE:  begin cls_kind = KIND_MISS; cls_data = '0;            end
            default:  ;
        endcase
    end

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW-1:0] rd_next, wr_next;
    logic          empty, full, push, pop;

    assign empty     = (rd_ptr == wr_ptr);
    assign full      = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & (~full | pop);
    assign rd_next   = pop  ? rd_ptr + 1'b1 : rd_ptr;
    assign wr_next   = push ? wr_ptr + 1'b1 : wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cls_kind, cls_data};
        end
    end

    // Head is a register so it holds its last value once the FIFO drains;
    // a word landing in the slot that becomes head is bypassed from the input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            data_out <= '0;
            out_kind <= KIND_HIT;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;
            if (rd_next != wr_next) begin
                if (push && (rd_next[AW-1:0] == wr_ptr[AW-1:0])) begin
                    {out_kind, data_out} <= {cls_kind, cls_data};
                end else begin
                    {out_kind, data_out} <= mem[rd_next[AW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            hit_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            if (in_valid && full && !pop) begin
                overflow <= 1'b1;
            end
            if (push && (cls_kind == KIND_HIT) && (hit_cnt != {CNT_W{1'b1}})) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (push && (cls_kind == KIND_ERR) && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
